// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pkg
// Purpose  : Shared types and defaults for the instruction-fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

  // Fetch FSM encoding
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    FLUSHWAIT = 2'd2
  } fetch_state_t;

  localparam int DEF_DEPTH  = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int ENTRY_W    = DEF_ADDR_W + DEF_DATA_W;

endpackage
`default_nettype wire

// File: rtl/if_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_fifo
// Purpose  : Synchronous show-ahead FIFO holding {PC, instruction} pairs.
//            The head entry is always visible; clear empties it in one edge.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int WIDTH = ENTRY_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge Clk) begin
    if (Reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage; cleared on reset so the head reads zero out of reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction-fetch reader. Issues one req/ack read per PC value,
//            buffers {PC, instr} in a show-ahead FIFO and drives PCHold so the
//            PC advances once per accepted fetch or redirect.
// Options  : IF_STALL_COUNT_EN adds a saturating 32-bit stall counter output
//            (debug_StallCount).
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit
  import if_fetch_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PCResult,
  output logic              PCHold,
  input  logic              Flush,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic              IMemAck,
  input  logic [DATA_W-1:0] IMemData,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [DATA_W-1:0] InstrOut,
  output logic [ADDR_W-1:0] PCOut
`ifdef IF_STALL_COUNT_EN
  ,
  output logic [31:0]       debug_StallCount
`endif
);

  localparam int             c_ENTRY_W = ADDR_W + DATA_W;
  localparam int             c_CNT_W   = $clog2(DEPTH) + 1;
  localparam [c_CNT_W-1:0]   c_DEPTH   = c_CNT_W'(DEPTH);

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic                r_req;
  logic                w_req_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_ack;
  logic                w_push;
  logic                w_pop;
  logic [c_CNT_W-1:0]  w_count;
  logic [c_ENTRY_W-1:0] w_head;

  assign w_ack = r_req & IMemAck;

  // FSM and request registers; reset abandons any outstanding request
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Next-state, request and push decode; Flush overrides normal progress
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!Flush && (w_count < c_DEPTH)) begin
          w_state_nxt = BUSY;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = PCResult;
        end
      end
      BUSY: begin
        if (w_ack) begin
          w_push      = !Flush;
          w_req_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end else if (Flush) begin
          w_state_nxt = FLUSHWAIT;
        end
      end
      FLUSHWAIT: begin
        if (w_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // PC may only load on a redirect or on completion of a kept fetch
  always_comb begin
    PCHold = 1'b1;
    if (!Reset && (Flush || ((r_state == BUSY) && w_ack))) PCHold = 1'b0;
  end

  assign w_pop = InstrValid & InstrReady & ~Flush;

  if_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (Flush),
    .i_data  ({r_addr, IMemData}),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign IMemReq    = r_req;
  assign IMemAddr   = r_addr;
  assign InstrValid = (w_count != '0);
  assign InstrOut   = w_head[DATA_W-1:0];
  assign PCOut      = w_head[c_ENTRY_W-1 -: ADDR_W];

`ifdef IF_STALL_COUNT_EN
  logic [31:0] r_stall_cnt;

  // Count cycles in which the PC is held without a redirect, saturating
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cnt <= '0;
    end else if (PCHold && !Flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign debug_StallCount = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Directed self-checking bench for if_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PCResult;
  logic        PCHold;
  logic        Flush;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrOut;
  logic [31:0] PCOut;
`ifdef IF_STALL_COUNT_EN
  logic [31:0] debug_StallCount;
`endif

  logic [31:0] pc;
  logic [31:0] flush_target;
  logic        ack_en;
  logic        ovr;
  int          mem_lat;
  int          mem_wait;
  int          vectors = 0;
  int          miscompares = 0;

  if_fetch_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PCResult   (PCResult),
    .PCHold     (PCHold),
    .Flush      (Flush),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemAck    (IMemAck),
    .IMemData   (IMemData),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .InstrOut   (InstrOut),
    .PCOut      (PCOut)
`ifdef IF_STALL_COUNT_EN
    ,
    .debug_StallCount (debug_StallCount)
`endif
  );

  always #5 Clk = ~Clk;

  // PC register model
  always @(posedge Clk) begin
    if (Reset)        pc <= 32'h0;
    else if (Flush)   pc <= flush_target;
    else if (!PCHold) pc <= pc + 32'd4;
  end
  assign PCResult = pc;

  // Instruction memory model with programmable ack latency
  always @(posedge Clk) begin
    if (Reset || !IMemReq || IMemAck) mem_wait <= 0;
    else                              mem_wait <= mem_wait + 1;
  end
  assign IMemAck  = IMemReq && ack_en && (mem_wait >= mem_lat);
  assign IMemData = ovr ? 32'hDEAD_BEEF : (IMemAddr ^ 32'hA5A5_0000);

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0; InstrReady = 1'b1; flush_target = 32'h0;
    ack_en = 1'b1; mem_lat = 0; ovr = 1'b0;
    repeat (3) tick();
    chk("rst_req",   IMemReq,    0);
    chk("rst_addr",  IMemAddr,   0);
    chk("rst_valid", InstrValid, 0);
    chk("rst_instr", InstrOut,   0);
    chk("rst_pcout", PCOut,      0);
    chk("rst_hold",  PCHold,     1);
    chk("rst_state", 2'(dut.r_state), 0);
`ifdef IF_STALL_COUNT_EN
    chk("rst_stall", debug_StallCount, 0);
`endif

    // ---- Test 1: zero-wait streaming
    Reset = 1'b0; #1;
    chk("t1_c0_valid", InstrValid, 0);
    chk("t1_c0_req",   IMemReq,    0);
    tick();
    chk("t1_c1_req",   IMemReq,  1);
    chk("t1_c1_addr",  IMemAddr, 32'h0);
    chk("t1_c1_hold",  PCHold,   0);
    chk("t1_c1_valid", InstrValid, 0);
    tick();
    chk("t1_c2_valid", InstrValid, 1);
    chk("t1_c2_instr", InstrOut, 32'hA5A5_0000);
    chk("t1_c2_pcout", PCOut,    32'h0);
    chk("t1_c2_req",   IMemReq,  0);
    tick();
    chk("t1_c3_addr",  IMemAddr, 32'h4);
    chk("t1_c3_valid", InstrValid, 0);
    tick();
    chk("t1_c4_instr", InstrOut, 32'hA5A5_0004);
    chk("t1_c4_pcout", PCOut,    32'h4);
    tick();
    chk("t1_c5_addr",  IMemAddr, 32'h8);
    tick();
    chk("t1_c6_instr", InstrOut, 32'hA5A5_0008);
    chk("t1_c6_pcout", PCOut,    32'h8);

    // ---- Test 2: redirect to 0x10, then 3-cycle memory latency
    Flush = 1'b1; flush_target = 32'h10; mem_lat = 3; #1;
    chk("t2_flush_hold", PCHold, 0);
    tick();
    Flush = 1'b0; #1;
    chk("t2_c7_valid", InstrValid, 0);
    chk("t2_c7_req",   IMemReq,    0);
    chk("t2_c7_pc",    pc,         32'h10);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t2_wait_req",  IMemReq,  1);
      chk("t2_wait_addr", IMemAddr, 32'h10);
      chk("t2_wait_hold", PCHold,   1);
      chk("t2_wait_pc",   pc,       32'h10);
      tick();
    end
    chk("t2_ack_hold", PCHold, 0);
    chk("t2_ack_addr", IMemAddr, 32'h10);
    tick();
    chk("t2_after_pc",    pc,       32'h14);
    chk("t2_after_valid", InstrValid, 1);
    chk("t2_after_pcout", PCOut,    32'h10);
    chk("t2_after_instr", InstrOut, 32'hA5A5_0010);
    chk("t2_after_req",   IMemReq,  0);

    // ---- Test 3: consumer stalled, FIFO fills to DEPTH
    Reset = 1'b1; InstrReady = 1'b0; mem_lat = 0;
    tick(); tick();
    Reset = 1'b0; #1;
    repeat (4) tick();
    chk("t3_full_count", dut.w_count, 2);
    chk("t3_full_pcout", PCOut, 32'h0);
    chk("t3_full_req",   IMemReq, 0);
    tick();
    chk("t3_c5_req",  IMemReq, 0);
    chk("t3_c5_hold", PCHold,  1);
    chk("t3_c5_pc",   pc,      32'h8);
    tick();
    chk("t3_c6_req",  IMemReq, 0);
    chk("t3_c6_hold", PCHold,  1);
    InstrReady = 1'b1;
    tick();
    chk("t3_c7_valid", InstrValid, 1);
    chk("t3_c7_pcout", PCOut,    32'h4);
    chk("t3_c7_instr", InstrOut, 32'hA5A5_0004);
    tick();
    chk("t3_c8_req",  IMemReq,  1);
    chk("t3_c8_addr", IMemAddr, 32'h8);
    tick();
    chk("t3_c9_pcout", PCOut, 32'h8);

    // ---- Test 4: Flush while request outstanding, late ack discarded
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0; #1;
    repeat (4) tick();
    ack_en = 1'b0;
    tick();
    chk("t4_c5_req",  IMemReq,  1);
    chk("t4_c5_addr", IMemAddr, 32'h8);
    Flush = 1'b1; flush_target = 32'h40; ovr = 1'b1; #1;
    chk("t4_c5_hold", PCHold, 0);
    tick();
    Flush = 1'b0; #1;
    chk("t4_c6_valid", InstrValid, 0);
    chk("t4_c6_count", dut.w_count, 0);
    chk("t4_c6_req",   IMemReq, 1);
    chk("t4_c6_state", 2'(dut.r_state), 2);
    chk("t4_c6_hold",  PCHold, 1);
    chk("t4_c6_pc",    pc, 32'h40);
    tick();
    ack_en = 1'b1; #1;
    chk("t4_c7_hold",  PCHold, 1);
    chk("t4_c7_valid", InstrValid, 0);
    tick();
    ovr = 1'b0;
    chk("t4_c8_req",   IMemReq, 0);
    chk("t4_c8_valid", InstrValid, 0);
    chk("t4_c8_pc",    pc, 32'h40);
    chk("t4_c8_state", 2'(dut.r_state), 0);
    tick();
    chk("t4_c9_req",  IMemReq,  1);
    chk("t4_c9_addr", IMemAddr, 32'h40);
    tick();
    chk("t4_c10_valid", InstrValid, 1);
    chk("t4_c10_pcout", PCOut,    32'h40);
    chk("t4_c10_instr", InstrOut, 32'hA5A5_0040);
    InstrReady = 1'b0;

    // ---- Test 5: Flush coincident with ack and a poppable head
    tick();
    chk("t5_c11_req",   IMemReq,  1);
    chk("t5_c11_addr",  IMemAddr, 32'h44);
    chk("t5_c11_valid", InstrValid, 1);
    InstrReady = 1'b1; Flush = 1'b1; flush_target = 32'h80; #1;
    chk("t5_c11_hold", PCHold, 0);
    tick();
    Flush = 1'b0; #1;
    chk("t5_c12_count", dut.w_count, 0);
    chk("t5_c12_valid", InstrValid, 0);
    chk("t5_c12_state", 2'(dut.r_state), 0);
    chk("t5_c12_req",   IMemReq, 0);
    chk("t5_c12_pc",    pc, 32'h80);
    ack_en = 1'b0;
    tick();
    chk("t5_c13_req",   IMemReq,  1);
    chk("t5_c13_addr",  IMemAddr, 32'h80);
    chk("t6_busy_state", 2'(dut.r_state), 1);

    // ---- Test 6: Reset while BUSY
    Reset = 1'b1; #1;
    chk("t6_rst_hold", PCHold, 1);
    tick();
    chk("t6_req",   IMemReq, 0);
    chk("t6_valid", InstrValid, 0);
    chk("t6_state", 2'(dut.r_state), 0);
`ifdef IF_STALL_COUNT_EN
    chk("t6_stall", debug_StallCount, 0);
`endif
    Reset = 1'b0; ack_en = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
